// File: rtl/avfcl_interval_reporter.sv
// Snapshots six AVF accumulators at every window end and streams the
// per-structure modular deltas out as a six-beat valid/ready report.
module avfcl_interval_reporter #(
  parameter int ACC_W    = 25,
  parameter int INTERVAL = 65536,
  parameter int WIN_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [6*ACC_W-1:0] acc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_id,
  output logic [ACC_W-1:0]   out_delta,
  output logic [WIN_W-1:0]   out_window,
  output logic               out_last,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam int NUM_S = 6;
  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic {IDLE, SEND} state_t;

  logic [ACC_W-1:0] acc_w   [NUM_S];
  logic [ACC_W-1:0] prev_q  [NUM_S];
  logic [ACC_W-1:0] delta_q [NUM_S];
  state_t           state_q;
  logic [2:0]       idx_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q;
  logic             tc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_S; gi++) begin : g_unpack
      assign acc_w[gi] = acc_in[gi*ACC_W +: ACC_W];
    end
  endgenerate

  always_comb begin
    tc    = enable && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Deltas are computed once at the window end so the report is stable
  // however long the consumer back-pressures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      win_q   <= '0;
      for (int k = 0; k < NUM_S; k++) begin
        prev_q[k]  <= '0;
        delta_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (tc) begin
            for (int k = 0; k < NUM_S; k++) begin
              delta_q[k] <= acc_w[k] - prev_q[k];
              prev_q[k]  <= acc_w[k];
            end
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              win_q   <= win_q + 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A window end that lands while a report is draining is dropped; a
  // coincident clear loses to the new event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (tc && (state_q == SEND)) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign out_valid  = (state_q == SEND);
  assign out_id     = idx_q;
  assign out_delta  = delta_q[idx_q];
  assign out_window = win_q;
  assign out_last   = (state_q == SEND) && (idx_q == LAST_IDX);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_avfcl_interval_reporter.sv
// Randomised bench for avfcl_interval_reporter against a queue-of-beats model,
// with directed scenarios pinning latency, wrap, back-pressure and reset.
module tb_avfcl_interval_reporter;
  localparam int ACC_W    = 25;
  localparam int INTERVAL = 8;
  localparam int WIN_W    = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic [6*ACC_W-1:0] acc_in = '0;
  logic               out_ready = 1'b0;
  logic               clr_overrun = 1'b0;
  logic               out_valid;
  logic [2:0]         out_id;
  logic [ACC_W-1:0]   out_delta;
  logic [WIN_W-1:0]   out_window;
  logic               out_last;
  logic               overrun;

  always #5 clk = ~clk;

  avfcl_interval_reporter #(.ACC_W(ACC_W), .INTERVAL(INTERVAL), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_delta(out_delta), .out_window(out_window), .out_last(out_last),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic [2:0]       id;
    logic [ACC_W-1:0] delta;
    logic [WIN_W-1:0] win;
    logic             last;
  } beat_t;

  // Model: a window end while idle enqueues the whole six-beat report.
  beat_t            m_q[$];
  logic [ACC_W-1:0] m_prev[6];
  logic [WIN_W-1:0] m_win;
  bit               m_ovr;
  int               m_en_cnt;

  beat_t log_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    iter = 0;
  int    last_rise = 0;
  int    first_rise = 0;
  bit    rose = 0;
  bit    prev_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [ACC_W-1:0] acc_k(input int k);
    return acc_in[k*ACC_W +: ACC_W];
  endfunction

  task automatic set_acc(input int k, input logic [ACC_W-1:0] v);
    acc_in[k*ACC_W +: ACC_W] = v;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < 6; k++) m_prev[k] = '0;
    m_win = '0;
    m_ovr = 0;
    m_en_cnt = 0;
  endtask

  task automatic model_step();
    bit busy;
    bit tc;
    beat_t b;
    busy = (m_q.size() > 0);
    tc = 0;
    if (enable) begin
      tc = ((m_en_cnt % INTERVAL) == INTERVAL - 1);
      m_en_cnt++;
    end
    if (tc && busy) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    if (busy && out_ready) begin
      b = m_q.pop_front();
      if (b.last) m_win = m_win + 1'b1;
    end
    if (tc && !busy) begin
      for (int k = 0; k < 6; k++) begin
        b.id    = 3'(k);
        b.delta = acc_k(k) - m_prev[k];
        b.win   = m_win;
        b.last  = (k == 5);
        m_q.push_back(b);
        m_prev[k] = acc_k(k);
      end
    end
  endtask

  task automatic compare();
    if (m_q.size() == 0) begin
      chk("valid_idle", out_valid, 0);
    end else begin
      chk("valid", out_valid, 1);
      chk("id", out_id, m_q[0].id);
      chk("delta", out_delta, m_q[0].delta);
      chk("window", out_window, m_q[0].win);
      chk("last", out_last, m_q[0].last);
    end
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic cycle();
    beat_t b;
    @(posedge clk);
    iter++;
    if (reset) model_step();
    @(negedge clk);
    compare();
    rose = out_valid && !prev_valid;
    prev_valid = out_valid;
    if (rose) begin
      last_rise = iter;
      if (first_rise == 0) first_rise = iter;
    end
    if (out_valid && out_ready) begin
      b.id = out_id; b.delta = out_delta; b.win = out_window; b.last = out_last;
      log_q.push_back(b);
    end
  endtask

  task automatic wait_rise();
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 200) begin
      cycle();
      n++;
      if (rose) got = 1;
    end
    if (!got) chk("wait_rise_timeout", 0, 1);
  endtask

  initial begin
    int r0;
    int n;
    logic [ACC_W-1:0] raw0;

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_delta", out_delta, 0);
    chk("rst_out_window", out_window, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overrun", overrun, 0);

    // Constant accumulators over two windows.
    for (int k = 0; k < 6; k++) set_acc(k, ACC_W'(100 * (k + 1)));
    enable = 1; out_ready = 1; reset = 1;
    repeat (23) cycle();
    chk("first_beat_iter", first_rise, 8);
    chk("log_size", log_q.size(), 12);
    for (int k = 0; k < 6 && log_q.size() >= 12; k++) begin
      chk("w0_id", log_q[k].id, k);
      chk("w0_delta", log_q[k].delta, 100 * (k + 1));
      chk("w0_window", log_q[k].win, 0);
      chk("w0_last", log_q[k].last, (k == 5));
      chk("w1_delta", log_q[k+6].delta, 0);
      chk("w1_window", log_q[k+6].win, 1);
    end

    // Modular delta across accumulator wrap.
    set_acc(0, 25'h1FFFFF0);
    wait_rise();
    wait_rise();
    set_acc(0, 25'h0000010);
    wait_rise();
    chk("wrap_id", out_id, 0);
    chk("wrap_delta", out_delta, 25'h20);

    // Five disabled cycles push the next window end out by five.
    wait_rise();
    r0 = last_rise;
    repeat (2) cycle();
    enable = 0;
    repeat (5) cycle();
    enable = 1;
    wait_rise();
    chk("tc_gap", last_rise - r0, 13);

    // Back-pressure across several windows, growing IQ accumulator.
    out_ready = 0;
    repeat (20) begin
      set_acc(0, acc_k(0) + 1'b1);
      cycle();
    end
    chk("bp_valid", out_valid, 1);
    chk("bp_overrun", overrun, 1);
    out_ready = 1;
    repeat (12) begin
      set_acc(0, acc_k(0) + 1'b1);
      cycle();
    end
    clr_overrun = 1;
    cycle();
    clr_overrun = 0;
    chk("clr_overrun", overrun, 0);

    // Randomised traffic.
    repeat (1500) begin
      enable = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_overrun = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 6; k++)
        if ($urandom_range(0, 3) == 0) set_acc(k, ACC_W'($urandom));
      cycle();
    end
    clr_overrun = 0;
    enable = 1;
    out_ready = 1;

    // Reset in the middle of a report.
    n = 0;
    while (!(out_valid && out_id == 3) && n < 100) begin
      cycle();
      n++;
    end
    chk("reach_id3", (out_valid && out_id == 3), 1);
    reset = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_id", out_id, 0);
    model_reset();
    prev_valid = 0;
    cycle();
    for (int k = 0; k < 6; k++) set_acc(k, ACC_W'($urandom));
    raw0 = acc_k(0);
    reset = 1;
    wait_rise();
    chk("post_rst_window", out_window, 0);
    chk("post_rst_id", out_id, 0);
    chk("post_rst_delta0", out_delta, raw0);
    repeat (8) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
